// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_pkg
// Description : Shared state encoding and constants for the UART TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_TAG  = 2'd1,
        SEND_DATA = 2'd2
    } arb_state_t;

    localparam logic [7:0] c_TAG_BASE_DEFAULT = 8'hF0;

endpackage : uart_tx_arbiter_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester-side and transmitter-side handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_valid;
    logic                          tx_ready;
    logic [IDX_W-1:0]              grant_id;
    logic                          busy;

    // slave: the arbiter itself; master: requesters plus transmitter
    modport slave (
        input  req_valid, req_data, tx_ready,
        output req_ready, tx_data, tx_valid, grant_id, busy
    );

    modport master (
        output req_valid, req_data, tx_ready,
        input  req_ready, tx_data, tx_valid, grant_id, busy
    );

endinterface : uart_tx_arbiter_if
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_select
// Description : Combinational round-robin picker, search starts at ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0]   i_ptr,
    output logic      [IDX_W-1:0]   o_winner,
    output logic                    o_any_valid
);

    // Explicit wrap so non-power-of-two NUM_REQ never indexes past the end
    always_comb begin
        int v_idx;
        o_winner    = '0;
        o_any_valid = 1'b0;
        v_idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = int'(i_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            if (!o_any_valid && i_req[v_idx[IDX_W-1:0]]) begin
                o_winner    = IDX_W'(v_idx);
                o_any_valid = 1'b1;
            end
        end
    end

endmodule : rr_select
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin share of one UART transmitter, optional tag byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int                    NUM_REQ    = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    TAG_ENABLE = 1'b1,
    parameter logic [DATA_WIDTH-1:0] TAG_BASE   = DATA_WIDTH'(c_TAG_BASE_DEFAULT)
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        ena,
    uart_tx_arbiter_if.slave bus
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    arb_state_t              r_state;
    logic [DATA_WIDTH-1:0]   r_hold;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic [c_IDX_W-1:0]      r_grant;
    logic [c_IDX_W-1:0]      r_rr_ptr;

    logic [c_IDX_W-1:0]      w_winner;
    logic                    w_any_valid;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [DATA_WIDTH-1:0]   w_tag;
    logic                    w_req_accept;
    logic                    w_tx_active;
    logic                    w_tx_fire;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_select (
        .i_req       (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .o_winner    (w_winner),
        .o_any_valid (w_any_valid)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == c_IDX_W'(i)) begin
                w_sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_tag        = TAG_BASE | DATA_WIDTH'(w_winner);
    assign w_req_accept = (r_state == IDLE) && ena && !reset && w_any_valid;
    assign w_tx_active  = (r_state != IDLE) && ena && !reset;
    assign w_tx_fire    = w_tx_active && bus.tx_ready;

    always_comb begin
        bus.req_ready = '0;
        if (w_req_accept) begin
            bus.req_ready[w_winner] = 1'b1;
        end
    end

    assign bus.tx_valid = w_tx_active;
    assign bus.tx_data  = r_tx_data;
    assign bus.grant_id = r_grant;
    assign bus.busy     = (r_state != IDLE);

    // r_tx_data is loaded one state ahead so tx_data never depends on tx_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_rr_ptr  <= c_IDX_W'(NUM_REQ - 1);
            r_hold    <= '0;
            r_grant   <= '0;
            r_tx_data <= '0;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    if (w_req_accept) begin
                        r_hold   <= w_sel_data;
                        r_grant  <= w_winner;
                        r_rr_ptr <= w_winner;
                        if (TAG_ENABLE) begin
                            r_state   <= SEND_TAG;
                            r_tx_data <= w_tag;
                        end else begin
                            r_state   <= SEND_DATA;
                            r_tx_data <= w_sel_data;
                        end
                    end
                end
                SEND_TAG: begin
                    if (w_tx_fire) begin
                        r_state   <= SEND_DATA;
                        r_tx_data <= r_hold;
                    end
                end
                SEND_DATA: begin
                    if (w_tx_fire) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Randomized scoreboard bench for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int         N    = 4;
    localparam int         DW   = 8;
    localparam logic [7:0] TAGB = 8'hF0;

    typedef struct {
        logic [7:0] b;
        int         g;
        int         avail;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic ena   = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_grant = N - 1;
    exp_t q[$];

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .TAG_ENABLE (1'b1),
        .TAG_BASE   (TAGB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: first valid requester circularly after the last one served
    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Requester-side model: decides grants and pushes the expected byte stream
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                q.delete();
                last_grant = N - 1;
            end else if (q.size() == 0 && ena) begin
                int         w;
                logic [N-1:0] exp_rdy;
                exp_t       e;
                w = pick(bus.req_valid, last_grant);
                exp_rdy = (w >= 0) ? N'(1 << w) : '0;
                check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
                if (w >= 0) begin
                    e.g = w;
                    e.avail = cyc + 1;
                    e.b = TAGB | 8'(w);
                    q.push_back(e);
                    e.b = bus.req_data[w*DW +: DW];
                    q.push_back(e);
                    last_grant = w;
                end
            end else begin
                check("req_ready_idle", 32'(bus.req_ready), 32'd0);
            end
        end
    end

    // Transmitter-side monitor: pops and compares whatever the DUT offers
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                bit pend;
                pend = (q.size() > 0) && (q[0].avail <= cyc);
                check("busy", 32'(bus.busy), 32'(pend));
                check("tx_valid", 32'(bus.tx_valid), 32'(pend && ena));
                if (pend && bus.tx_valid) begin
                    check("tx_data", 32'(bus.tx_data), 32'(q[0].b));
                    check("grant_id", 32'(bus.grant_id), 32'(q[0].g));
                    if (bus.tx_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic drive_random(input int cycles, input int p_valid, input int p_ready, input int p_ena);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            for (int r = 0; r < N; r++) begin
                bus.req_valid[r] = ($urandom_range(99) < p_valid);
                bus.req_data[r*DW +: DW] = 8'($urandom);
            end
            bus.tx_ready = ($urandom_range(99) < p_ready);
            ena = ($urandom_range(99) < p_ena);
        end
    endtask

    task automatic drive_fixed(input int cycles, input logic [N-1:0] v, input logic rdy, input logic en);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.req_valid = v;
            bus.tx_ready  = rdy;
            ena           = en;
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_ready  = 1'b0;

        // Reset state, with all requests raised to show reset blocks req_ready
        @(negedge clk);
        ena = 1'b1;
        bus.req_valid = '1;
        @(negedge clk);
        #3;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_grant", 32'(bus.grant_id), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        @(negedge clk);
        bus.req_valid = '0;
        reset = 1'b0;

        // Single requester 0 with byte 41
        bus.req_data[0 +: DW] = 8'h41;
        drive_fixed(1, 4'b0001, 1'b1, 1'b1);
        drive_fixed(8, 4'b0000, 1'b1, 1'b1);

        // All four continuously valid, bytes 10..13
        for (int r = 0; r < N; r++) bus.req_data[r*DW +: DW] = 8'(8'h10 + r);
        drive_fixed(40, 4'b1111, 1'b1, 1'b1);
        drive_fixed(4, 4'b0000, 1'b1, 1'b1);

        // Requesters 1 and 3 only
        drive_fixed(12, 4'b1010, 1'b1, 1'b1);
        drive_fixed(4, 4'b0000, 1'b1, 1'b1);

        // Stalled transmitter in SEND_TAG for 50 cycles
        drive_fixed(1, 4'b0100, 1'b0, 1'b1);
        drive_fixed(50, 4'b1111, 1'b0, 1'b1);
        drive_fixed(6, 4'b0000, 1'b1, 1'b1);

        // ena low for 10 cycles while in SEND_DATA
        drive_fixed(1, 4'b0010, 1'b0, 1'b1);
        drive_fixed(1, 4'b0000, 1'b1, 1'b1);
        drive_fixed(1, 4'b0000, 1'b0, 1'b1);
        drive_fixed(10, 4'b1111, 1'b1, 1'b0);
        drive_fixed(6, 4'b0000, 1'b1, 1'b1);

        // Reset in SEND_DATA with requester 2 pending
        drive_fixed(1, 4'b0100, 1'b0, 1'b1);
        drive_fixed(1, 4'b0000, 1'b1, 1'b1);
        drive_fixed(1, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        reset = 1'b0;
        #3;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        drive_fixed(8, 4'b0100, 1'b1, 1'b1);
        drive_fixed(4, 4'b0000, 1'b1, 1'b1);

        // Randomized traffic with stalls, enables and dropping requests
        drive_random(1500, 50, 60, 90);
        drive_random(500, 90, 30, 75);

        // Drain
        drive_fixed(20, 4'b0000, 1'b1, 1'b1);
        #3;
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
